// File: rtl/seg7_pkg.sv
// Shared seven-segment constants, decode table and capture FSM states.
// Used by both the encoder path and the seven_seg_capture receiver.
package seg7_pkg;

    // Active-low patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h18;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_9_ALT = 7'h10;
    localparam logic [6:0] SEG_7_ALT = 7'h58;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Encoder-side table, indexed by nibble
    localparam logic [6:0] SEG_TABLE [16] = '{
        SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
        SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
    };

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        ACCEPT,
        HOLD
    } cap_state_t;

    // Returns {valid, nibble}; invalid patterns give nibble 0
    function automatic logic [4:0] seg7_decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            SEG_0:     r = 5'h10;
            SEG_1:     r = 5'h11;
            SEG_2:     r = 5'h12;
            SEG_3:     r = 5'h13;
            SEG_4:     r = 5'h14;
            SEG_5:     r = 5'h15;
            SEG_6:     r = 5'h16;
            SEG_7:     r = 5'h17;
            SEG_7_ALT: r = 5'h17;
            SEG_8:     r = 5'h18;
            SEG_9:     r = 5'h19;
            SEG_9_ALT: r = 5'h19;
            SEG_A:     r = 5'h1A;
            SEG_B:     r = 5'h1B;
            SEG_C:     r = 5'h1C;
            SEG_D:     r = 5'h1D;
            SEG_E:     r = 5'h1E;
            SEG_F:     r = 5'h1F;
            default:   r = 5'h00;
        endcase
        return r;
    endfunction

    // Exactly one active-low enable asserted
    function automatic logic dig_legal(input logic [3:0] dig_n);
        logic [3:0] on;
        on = ~dig_n;
        return (on != 4'h0) && ((on & (on - 4'h1)) == 4'h0);
    endfunction

    function automatic logic [1:0] dig_index(input logic [3:0] dig_n);
        logic [1:0] r;
        case (dig_n)
            4'b1101: r = 2'd1;
            4'b1011: r = 2'd2;
            4'b0111: r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seven_seg_capture_sync2.sv
// Parameterized-width two-flop synchronizer with async reset value.
// Ports: clk, rst_n (async, active-low), d (async input), q (synced).
module sync2 #(
    parameter int         W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/seven_seg_capture.sv
// Scanned 4-digit seven-segment bus receiver: debounce, decode, frame.
// Ports: clk, reset_n, seg_n[6:0], dig_n[3:0] in; value[15:0],
// frame_valid, frame_err, digit_err[3:0], stalled out.
module seven_seg_capture
    import seg7_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [6:0]  seg_n,
    input  logic [3:0]  dig_n,
    output logic [15:0] value,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [3:0]  digit_err,
    output logic        stalled
);

    localparam logic [7:0]  SET = 8'(SETTLE_CYCLES);
    localparam logic [19:0] TMO = 20'(TIMEOUT_CYCLES);

    logic        rst_n;
    logic [6:0]  seg_s;
    logic [3:0]  dig_s;

    sync2 #(.W(1), .RST_VAL(1'b0)) u_rst (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (1'b1),
        .q     (rst_n)
    );

    sync2 #(.W(7), .RST_VAL(7'h7F)) u_seg (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (seg_n),
        .q     (seg_s)
    );

    sync2 #(.W(4), .RST_VAL(4'hF)) u_dig (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (dig_n),
        .q     (dig_s)
    );

    logic [10:0] key;
    logic        legal;
    assign key   = {dig_s, seg_s};
    assign legal = dig_legal(dig_s);

    cap_state_t  state, state_d;
    logic [10:0] key_q, key_d;
    logic [7:0]  cnt, cnt_d;
    logic        restart;

    // A key change in any state is treated as the first sample of a new
    // run, so no sample is lost between adjacent digit slots.
    always_comb begin
        state_d = state;
        key_d   = key_q;
        cnt_d   = cnt;
        restart = 1'b0;
        unique case (state)
            IDLE: restart = 1'b1;
            SETTLE: begin
                if (key != key_q) begin
                    restart = 1'b1;
                end else begin
                    cnt_d = cnt + 8'd1;
                    if (cnt_d == SET) state_d = ACCEPT;
                end
            end
            ACCEPT: begin
                if (key != key_q) restart = 1'b1;
                else              state_d = HOLD;
            end
            HOLD: begin
                if (key != key_q) restart = 1'b1;
            end
        endcase
        if (restart) begin
            if (legal) begin
                key_d   = key;
                cnt_d   = 8'd1;
                state_d = (SET == 8'd1) ? ACCEPT : SETTLE;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            key_q <= '0;
            cnt   <= '0;
        end else begin
            state <= state_d;
            key_q <= key_d;
            cnt   <= cnt_d;
        end
    end

    logic [3:0]  mask, mask_n, err_n, bit_sel;
    logic [15:0] stage, stage_n;
    logic [4:0]  dec;
    logic [1:0]  idx;
    logic        accept, done;
    logic [19:0] tmo;

    always_comb begin
        accept  = (state == ACCEPT);
        dec     = seg7_decode(key_q[6:0]);
        idx     = dig_index(key_q[10:7]);
        bit_sel = 4'b0001 << idx;
        mask_n  = mask;
        err_n   = digit_err;
        stage_n = stage;
        if (accept) begin
            mask_n = mask | bit_sel;
            stage_n[{idx, 2'b00} +: 4] = dec[3:0];
            if (!dec[4]) err_n = digit_err | bit_sel;
        end
        // Completion folds in this cycle's accept, including its error
        done = accept && (mask_n == 4'hF);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask        <= '0;
            stage       <= '0;
            digit_err   <= '0;
            value       <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            tmo         <= '0;
        end else begin
            mask        <= done ? 4'h0 : mask_n;
            stage       <= stage_n;
            digit_err   <= done ? 4'h0 : err_n;
            value       <= done ? stage_n : value;
            frame_valid <= done;
            frame_err   <= done & (|err_n);
            if (accept)          tmo <= '0;
            else if (tmo != TMO) tmo <= tmo + 20'd1;
        end
    end

    assign stalled = (tmo == TMO);

endmodule
